// File: rtl/i2s_tdm_port.sv
// Serial audio port for N-channel TDM frames in DSP or I2S framing.
// Bridges externally clocked codec pins to frame-wide parallel sample words on clk.
module i2s_tdm_port #(
  parameter int BITS      = 24,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int MODE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i2s_sclk,
  input  logic                     i2s_lrclk,
  input  logic                     i2s_dout,
  output logic                     i2s_din,
  input  logic [CHANNELS*BITS-1:0] audio_o,
  output logic [CHANNELS*BITS-1:0] audio_i,
  output logic                     rx_valid,
  output logic                     frame_err
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int AW         = CHANNELS * BITS;
  localparam int CW         = $clog2(FRAME_BITS + 1);
  localparam int OW         = $clog2(SLOT_BITS);
  localparam int SW         = $clog2(CHANNELS + 1);
  localparam int AIW        = $clog2(AW);

  localparam logic [CW-1:0] CNT_IDLE = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

  logic [1:0] sclk_sync;
  logic [1:0] lrclk_sync;
  logic [1:0] dout_sync;
  logic       sclk_d;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       fs;
  logic       sd;

  // Two sync flops per pin, then one aligned stage that yields the edge
  // strobes together with the frame-sync and data values seen at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      dout_sync  <= '0;
      sclk_d     <= 1'b0;
      sclk_rise  <= 1'b0;
      sclk_fall  <= 1'b0;
      fs         <= 1'b0;
      sd         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the shift chain below behaves as a real pipeline.
      sclk_sync  <= {sclk_sync[0], i2s_sclk};
      lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
      dout_sync  <= {dout_sync[0], i2s_dout};
      sclk_d     <= sclk_sync[1];
      sclk_rise  <= sclk_sync[1] & ~sclk_d;
      sclk_fall  <= ~sclk_sync[1] & sclk_d;
      fs         <= lrclk_sync[1];
      sd         <= dout_sync[1];
    end
  end

  logic [CW-1:0]  cnt;
  logic [OW-1:0]  off;
  logic [SW-1:0]  slot;
  logic           fs_prev;
  logic [AW-1:0]  rx_shadow;
  logic [AW-1:0]  tx_shadow;
  logic [AW-1:0]  rx_word;
  logic [AIW-1:0] samp_idx;
  logic           is_sample;
  logic           capture;
  logic           short_frame;
  logic           frame_start;

  // off/slot track cnt so the sample bit index needs no divider.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition,
    // which keeps it purely combinational.
    samp_idx    = AIW'(AW - 1 - int'(slot) * BITS - int'(off));
    is_sample   = int'(off) < BITS;
    capture     = cnt < CNT_IDLE;
    short_frame = cnt < CNT_LAST;
    frame_start = (MODE == 0) ? fs : (~fs & fs_prev);
    rx_word     = rx_shadow;
    if (is_sample) rx_word[samp_idx] = sd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample shadows are reset as well, so a reset mid-frame
      // leaves no stale partial frame to leak out later.
      cnt       <= CNT_IDLE;
      off       <= '0;
      slot      <= '0;
      fs_prev   <= 1'b0;
      rx_shadow <= '0;
      tx_shadow <= '0;
      audio_i   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      i2s_din   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (sclk_fall) begin
        fs_prev <= fs;
        if (capture) begin
          if (is_sample) rx_shadow[samp_idx] <= sd;
          cnt <= cnt + 1'b1;
          if (int'(off) == SLOT_BITS - 1) begin
            off  <= '0;
            slot <= slot + 1'b1;
          end else begin
            off <= off + 1'b1;
          end
          if (cnt == CNT_LAST) begin
            audio_i  <= rx_word;
            rx_valid <= 1'b1;
          end
        end
        // The start fall has already delivered the last bit of the old frame.
        if (frame_start) begin
          if (short_frame) begin
            frame_err <= 1'b1;
            rx_shadow <= '0;
          end
          cnt       <= '0;
          off       <= '0;
          slot      <= '0;
          tx_shadow <= audio_o;
        end
      end else if (sclk_rise) begin
        i2s_din <= (capture && is_sample) ? tx_shadow[samp_idx] : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_port.sv
// Directed bench: a DSP stereo 24/32 port and an I2S 4-channel 16/16 port
// share one SCLK; each is driven as a codec would drive it.
`timescale 1ns/1ps
module tb_i2s_tdm_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i2s_sclk;
  logic        lrclk_a, dout_a, din_a, rx_valid_a, frame_err_a;
  logic [47:0] audio_o_a, audio_i_a;
  logic        lrclk_b, dout_b, din_b, rx_valid_b, frame_err_b;
  logic [63:0] audio_o_b, audio_i_b;

  int total = 0;
  int bad   = 0;
  int valid_a = 0, err_a = 0, glitch_a = 0;
  int valid_b = 0, err_b = 0, glitch_b = 0;
  logic [47:0] prev_a;
  logic [63:0] prev_b;

  typedef struct {
    logic [47:0] tx;
    logic [63:0] rx;
    logic [47:0] exp_ai;
    logic [63:0] exp_din;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  i2s_tdm_port u_dsp (
    .clk(clk), .rst_n(rst_n), .i2s_sclk(i2s_sclk), .i2s_lrclk(lrclk_a),
    .i2s_dout(dout_a), .i2s_din(din_a), .audio_o(audio_o_a),
    .audio_i(audio_i_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a)
  );

  i2s_tdm_port #(.BITS(16), .SLOT_BITS(16), .CHANNELS(4), .MODE(1)) u_tdm (
    .clk(clk), .rst_n(rst_n), .i2s_sclk(i2s_sclk), .i2s_lrclk(lrclk_b),
    .i2s_dout(dout_b), .i2s_din(din_b), .audio_o(audio_o_b),
    .audio_i(audio_i_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b)
  );

  // Pulse counters and audio_i stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid_a) valid_a++;
    if (frame_err_a) err_a++;
    if (rx_valid_b) valid_b++;
    if (frame_err_b) err_b++;
    if (rst_n === 1'b1 && audio_i_a !== prev_a && !rx_valid_a) glitch_a++;
    if (rst_n === 1'b1 && audio_i_b !== prev_b && !rx_valid_b) glitch_b++;
    prev_a = audio_i_a;
    prev_b = audio_i_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end
  endtask

  // One SCLK period: rise (pins change), sample din, optional loopback, fall.
  task automatic sclk_period(input logic lr_a, input logic d_a, input logic lr_b,
                             input logic d_b, input bit loop_b,
                             output logic s_a, output logic s_b);
    i2s_sclk = 1'b1;
    lrclk_a  = lr_a;
    dout_a   = d_a;
    lrclk_b  = lr_b;
    dout_b   = d_b;
    #60;
    s_a = din_a;
    s_b = din_b;
    if (loop_b) dout_b = din_b;
    #20;
    i2s_sclk = 1'b0;
    #80;
  endtask

  task automatic dsp_frame(input logic [63:0] rx, input int nbits, input int start_at,
                           input logic [47:0] next_tx, output logic [63:0] ds);
    logic sa, sb;
    ds = '0;
    for (int j = 0; j < nbits; j++) begin
      sclk_period(j == start_at, (j < 64) ? rx[63-j] : 1'b1, 1'b0, 1'b0, 1'b0, sa, sb);
      if (j < 64) ds[63-j] = sa;
      if (j == 0) audio_o_a = next_tx;
    end
  endtask

  // I2S frame: LRCLK high over the second half, falling on the last bit.
  task automatic tdm_frame(input logic [63:0] next_tx, output logic [63:0] ds);
    logic sa, sb;
    ds = '0;
    for (int j = 0; j < 64; j++) begin
      sclk_period(1'b0, 1'b0, (j >= 31 && j < 63), 1'b0, 1'b1, sa, sb);
      ds[63-j] = sb;
      if (j == 0) audio_o_b = next_tx;
    end
  endtask

  initial begin
    logic [63:0] ds;
    logic [4:0]  idle_din;
    logic        sa, sb;

    vecs[0] = '{tx: 48'h800001_7FFFFF, rx: 64'h12345600_ABCDEF00,
                exp_ai: 48'h123456_ABCDEF, exp_din: 64'h80000100_7FFFFF00};
    vecs[1] = '{tx: 48'hA5A5A5_5A5A5A, rx: 64'h000001FF_FFFFFEAA,
                exp_ai: 48'h000001_FFFFFE, exp_din: 64'hA5A5A500_5A5A5A00};
    vecs[2] = '{tx: 48'h000000_FFFFFF, rx: 64'hC0FFEE00_12345600,
                exp_ai: 48'hC0FFEE_123456, exp_din: 64'h00000000_FFFFFF00};
    vecs[3] = '{tx: 48'hFEDCBA_012345, rx: 64'h80000055_7FFFFF00,
                exp_ai: 48'h800000_7FFFFF, exp_din: 64'hFEDCBA00_01234500};

    rst_n = 1'b0;
    i2s_sclk = 1'b0;
    lrclk_a = 1'b0; dout_a = 1'b0; lrclk_b = 1'b0; dout_b = 1'b0;
    audio_o_a = '0; audio_o_b = '0;
    #100;
    check("reset_din_a", din_a, 0);
    check("reset_audio_i_a", audio_i_a, 0);
    check("reset_pulses_a", {rx_valid_a, frame_err_a}, 0);
    check("reset_outs_b", {din_b, rx_valid_b, frame_err_b}, 0);
    check("reset_audio_i_b", audio_i_b, 0);
    rst_n = 1'b1;
    #100;

    // DSP table: lead-in start, then back-to-back frames.
    audio_o_a = vecs[0].tx;
    sclk_period(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sa, sb);
    for (int i = 0; i < 4; i++) begin
      dsp_frame(vecs[i].rx, 64, 63, (i < 3) ? vecs[i+1].tx : 48'h0, ds);
      check($sformatf("vec%0d_din", i), ds, vecs[i].exp_din);
      check($sformatf("vec%0d_audio_i", i), audio_i_a, vecs[i].exp_ai);
      check($sformatf("vec%0d_rx_valid_count", i), valid_a, i + 1);
      check($sformatf("vec%0d_frame_err_count", i), err_a, 0);
    end

    // Short frame of 40 bits.
    dsp_frame(64'hDEADBEEF_CAFEF00D, 40, 39, 48'h0, ds);
    check("short40_frame_err", err_a, 1);
    check("short40_rx_valid", valid_a, 4);
    check("short40_audio_i_held", audio_i_a, 48'h800000_7FFFFF);

    // One bit short: still an error.
    dsp_frame(64'hFFFFFFFF_FFFFFFFF, 63, 62, 48'h0, ds);
    check("short63_frame_err", err_a, 2);
    check("short63_audio_i_held", audio_i_a, 48'h800000_7FFFFF);

    dsp_frame(64'h5A5A5A00_C3C3C300, 64, 63, 48'h0, ds);
    check("after_short_audio_i", audio_i_a, 48'h5A5A5A_C3C3C3);
    check("after_short_rx_valid", valid_a, 5);

    // Padded frame: 4 extra SCLKs before the next start, no error.
    dsp_frame(64'h00000100_80000000, 68, 67, 48'hFFFFFF_FFFFFF, ds);
    check("padded_audio_i", audio_i_a, 48'h000001_800000);
    check("padded_rx_valid", valid_a, 6);
    check("padded_frame_err", err_a, 2);

    // Reset part-way through a frame carrying all-ones.
    dsp_frame(64'h0, 21, -1, 48'h0, ds);
    check("pre_reset_din", ds[63:43], 64'h1FFFFF);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_din", din_a, 0);
    check("midreset_audio_i", audio_i_a, 0);
    check("midreset_pulses", {rx_valid_a, frame_err_a}, 0);
    #48;
    rst_n = 1'b1;
    #100;
    for (int k = 0; k < 5; k++) begin
      sclk_period(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, sa, sb);
      idle_din[k] = sa;
    end
    check("idle_din", idle_din, 0);
    check("idle_rx_valid", valid_a, 6);
    sclk_period(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sa, sb);
    dsp_frame(64'hF00F0000_0FF0F0AA, 64, 63, 48'h0, ds);
    check("post_reset_audio_i", audio_i_a, 48'hF00F00_0FF0F0);
    check("post_reset_rx_valid", valid_a, 7);
    check("post_reset_frame_err", err_a, 2);
    check("tdm_idle_counts", {valid_b[31:0], err_b[31:0]}, 0);

    // I2S 4x16 loopback: din wired to dout, audio_o returns a frame later.
    audio_o_b = 64'h8001_7FFE_1234_FEDC;
    sclk_period(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sa, sb);
    sclk_period(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sa, sb);
    tdm_frame(64'h0F0F_F0F0_A5A5_5A5A, ds);
    check("tdm_f1_din", ds, 64'h8001_7FFE_1234_FEDC);
    check("tdm_f1_audio_i", audio_i_b, 64'h8001_7FFE_1234_FEDC);
    check("tdm_f1_rx_valid", valid_b, 1);
    tdm_frame(64'h0, ds);
    check("tdm_f2_din", ds, 64'h0F0F_F0F0_A5A5_5A5A);
    check("tdm_f2_audio_i", audio_i_b, 64'h0F0F_F0F0_A5A5_5A5A);
    check("tdm_f2_rx_valid", valid_b, 2);
    check("tdm_frame_err", err_b, 0);

    check("audio_i_a_stable", glitch_a, 0);
    check("audio_i_b_stable", glitch_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_port.md
# i2s_tdm_port

Parametrised serial audio port that generalises the SGTL5000 PCM Format A link to N-channel TDM frames, selectable DSP/I2S framing and independent sample/slot widths. It sits between the external codec serial pins (SCLK, frame sync, data in/out, all externally clocked) and the SID mixing/filter datapath running on the system clock. It exposes frame-wide parallel sample words and reports malformed frames.

## Interface
- BITS, 24: sample width per channel; 2 ≤ BITS ≤ SLOT_BITS.
- SLOT_BITS, 32: SCLK periods per channel slot.
- CHANNELS, 2: slots per frame, 1..8; FRAME_BITS = CHANNELS*SLOT_BITS ≤ 256.
- MODE, 0: 0 = DSP (frame sync high marks start); 1 = I2S (frame sync falling transition marks start).

- clk  in  1  system clock; must run ≥ 8× SCLK.
- rst_n  in  1  asynchronous, active-low reset.
- i2s_sclk  in  1  serial bit clock (asynchronous to clk).
- i2s_lrclk  in  1  frame sync / LRCLK.
- i2s_dout  in  1  serial data from codec.
- i2s_din  out  1  serial data to codec; reset 0.
- audio_o  in  CHANNELS*BITS  tx samples, signed; channel c at [(CHANNELS-c)*BITS-1 -: BITS] (channel 0 in MSBs).
- audio_i  out  CHANNELS*BITS  rx samples, same packing; reset 0.
- rx_valid  out  1  one-clk pulse when audio_i updates; reset 0.
- frame_err  out  1  one-clk pulse on short frame; reset 0.

## Operation
- Pin capture: i2s_sclk, i2s_lrclk, i2s_dout each pass through two sync flops; a third registered stage produces sclk_rise / sclk_fall strobes (one clk wide) with lrclk/dout delayed identically, so fs and sd are the pin values at the SCLK edge.
- Counter cnt (0..FRAME_BITS) = rx bits captured in the current frame; reset value FRAME_BITS (idle: no capture, tx drives 0 until first frame start).
- Frame start (evaluated on sclk_fall): MODE 0: fs=1. MODE 1: fs=0 and fs captured at previous sclk_fall was 1 (previous-fs register resets to 0).
- Every sclk_fall, in order:
  - if cnt < FRAME_BITS: capture sd into rx shadow bit position cnt; cnt+1. Capture that makes cnt=FRAME_BITS: copy rx shadow to audio_i, pulse rx_valid next clk.
  - if frame start: if cnt < FRAME_BITS-1 before this capture (short frame), discard shadow, no audio_i update, pulse frame_err; then cnt := 0, latch audio_o into tx shadow. Start fall therefore carries the final bit of the preceding frame (back-to-back frames without padding).
- Frame bit p: slot s = p / SLOT_BITS, offset k = p % SLOT_BITS. k < BITS carries sample bit BITS-1-k (MSB first); k ≥ BITS: tx drives 0, rx ignores.
- Every sclk_rise: i2s_din := tx bit at position cnt, or 0 if cnt = FRAME_BITS. Frame start is fall-only; a simultaneous rise/fall strobe cannot occur.
- Padding: falls after cnt=FRAME_BITS are ignored until the next frame start; no error.
- audio_o is sampled only at frame start; changes mid-frame take effect next frame.
- Reset mid-frame: all state returns to reset values immediately; partial frame lost, no rx_valid/frame_err.

## Timing
- SCLK pin edge → strobe: 3 clk; strobe → i2s_din / audio_i update: +1 clk.
- rx_valid and frame_err registered, asserted the clk after the causing fall strobe, high exactly one clk.
- Codec sees MSB of slot 0 on the first SCLK rise after the frame-start fall (DSP Format A; in MODE 1 gives I2S one-bit delay relative to LRCLK fall).
- audio_i stable between rx_valid pulses; changes only in the cycle rx_valid rises.

## Test plan
- Defaults, MODE 0, 64-SCLK frames, codec sends L=0x123456 R=0xABCDEF (8-bit zero pad per slot) -> after 2nd frame start audio_i = 0x123456ABCDEF, one rx_valid per frame, frame_err never.
- audio_o = 0x800001_7FFFFF -> i2s_din per frame: 1,0×22,1, 0×8, 0,1×23, 0×8 starting first rise after fs.
- CHANNELS=4, BITS=16, SLOT_BITS=16, back-to-back 64-bit frames, fs high during last bit -> last bit of slot 3 captured at start fall, audio_i correct, rx_valid every 64 SCLKs.
- MODE 1, LRCLK 50% at 64 SCLK -> channel 0 during LRCLK low, MSB one SCLK after LRCLK fall; loopback i2s_din→i2s_dout returns audio_o one frame later.
- Frame start after 40 SCLKs in 64-bit config -> frame_err pulse, audio_i unchanged, next full frame valid.
- rst_n low at bit 30 -> outputs 0 within async reset; no capture until next fs; first following frame produces no frame_err.
